// File: rtl/axi4_video_tpg_if.sv
// AXI4-Stream video bus carrying {R,G,B} pixels with SOF on tuser and EOL on tlast.
interface axi4_video_tpg_if #(
  parameter int unsigned PX_WIDTH = 10
) ();
  logic [3*PX_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axi4_video_tpg.sv
// AXI4-Stream test pattern generator: colour bars, grey ramp, checkerboard or solid frames.
// Define TPG_SCROLL_EN to add a per-frame horizontal scroll of the generated pattern.
module axi4_video_tpg #(
  parameter int unsigned X_RES      = 1920,
  parameter int unsigned Y_RES      = 1080,
  parameter int unsigned PX_WIDTH   = 10,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic [1:0]            pattern_i,
  input  logic [3*PX_WIDTH-1:0] solid_color_i,
  axi4_video_tpg_if.master      video,
  output logic                  busy_o,
  output logic                  frame_done_o
);
  localparam int unsigned XW    = (X_RES > 1) ? $clog2(X_RES) : 1;
  localparam int unsigned YW    = (Y_RES > 1) ? $clog2(Y_RES) : 1;
  localparam int unsigned DW    = 3 * PX_WIDTH;
  localparam int unsigned BAR_W = X_RES / 8;
  localparam logic [XW-1:0] X_MAX = XW'(X_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(Y_RES - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state, state_nx;
  logic [XW-1:0]     x, x_nx, xe_nx;
  logic [YW-1:0]     y, y_nx;
  logic [1:0]        pat, pat_nx;
  logic [DW-1:0]     solid, solid_nx;
  logic [DW-1:0]     tdata, tdata_nx;
  logic              tvalid, tvalid_nx, tlast, tlast_nx, tuser, tuser_nx;
  logic              busy, busy_nx, frame_done, frame_done_nx;
  logic              xfer, load;
`ifdef TPG_SCROLL_EN
  logic [XW-1:0]     offset, offset_nx;

  function automatic logic [XW-1:0] wrap_add(input logic [XW-1:0] a, input logic [XW-1:0] b);
    localparam int unsigned SW = XW + 1;
    logic [XW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SW'(X_RES)) s = s - SW'(X_RES);
    return XW'(s);
  endfunction
`endif

  function automatic logic [DW-1:0] pixel(input logic [XW-1:0] xe, input logic [YW-1:0] yy,
                                          input logic [1:0] p, input logic [DW-1:0] sc);
    logic [2:0]          bar;
    logic                c;
    logic [PX_WIDTH-1:0] r;
    bar = 3'(32'(xe) / BAR_W);
    c   = 1'((32'(xe) >> CHECK_LOG2) ^ (32'(yy) >> CHECK_LOG2));
    r   = PX_WIDTH'(xe);
    // bar index bits map directly onto the inverted R/G/B enables of the classic bar order
    case (p)
      2'd0:    return {{PX_WIDTH{~bar[1]}}, {PX_WIDTH{~bar[2]}}, {PX_WIDTH{~bar[0]}}};
      2'd1:    return {r, r, r};
      2'd2:    return c ? {DW{1'b0}} : {DW{1'b1}};
      default: return sc;
    endcase
  endfunction

  assign xfer = tvalid && video.tready;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nx;
  end

  // next state, next counters and the pixel for the next counter values
  always_comb begin
    state_nx      = state;
    x_nx          = x;
    y_nx          = y;
    pat_nx        = pat;
    solid_nx      = solid;
    tdata_nx      = tdata;
    tvalid_nx     = tvalid;
    tlast_nx      = tlast;
    tuser_nx      = tuser;
    busy_nx       = busy;
    frame_done_nx = 1'b0;
    load          = 1'b0;
`ifdef TPG_SCROLL_EN
    offset_nx     = offset;
`endif
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_nx  = ACTIVE;
          x_nx      = '0;
          y_nx      = '0;
          pat_nx    = pattern_i;
          solid_nx  = solid_color_i;
          tvalid_nx = 1'b1;
          busy_nx   = 1'b1;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          load = 1'b1;
          if (x == X_MAX) begin
            x_nx = '0;
            if (y == Y_MAX) begin
              y_nx          = '0;
              frame_done_nx = 1'b1;
              if (enable_i) begin
                pat_nx   = pattern_i;
                solid_nx = solid_color_i;
`ifdef TPG_SCROLL_EN
                offset_nx = (offset == X_MAX) ? '0 : offset + XW'(1);
`endif
              end else begin
                state_nx  = IDLE;
                tvalid_nx = 1'b0;
                busy_nx   = 1'b0;
                tlast_nx  = 1'b0;
                tuser_nx  = 1'b0;
                load      = 1'b0;
              end
            end else begin
              y_nx = y + YW'(1);
            end
          end else begin
            x_nx = x + XW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef TPG_SCROLL_EN
    xe_nx = wrap_add(x_nx, offset_nx);
`else
    xe_nx = x_nx;
`endif
    if (load) begin
      tdata_nx = pixel(xe_nx, y_nx, pat_nx, solid_nx);
      tuser_nx = (x_nx == '0) && (y_nx == '0);
      tlast_nx = (x_nx == X_MAX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      x          <= '0;
      y          <= '0;
      pat        <= '0;
      solid      <= '0;
      tdata      <= '0;
      tvalid     <= 1'b0;
      tlast      <= 1'b0;
      tuser      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef TPG_SCROLL_EN
      offset     <= '0;
`endif
    end else begin
      x          <= x_nx;
      y          <= y_nx;
      pat        <= pat_nx;
      solid      <= solid_nx;
      tdata      <= tdata_nx;
      tvalid     <= tvalid_nx;
      tlast      <= tlast_nx;
      tuser      <= tuser_nx;
      busy       <= busy_nx;
      frame_done <= frame_done_nx;
`ifdef TPG_SCROLL_EN
      offset     <= offset_nx;
`endif
    end
  end

  assign video.tdata  = tdata;
  assign video.tvalid = tvalid;
  assign video.tlast  = tlast;
  assign video.tuser  = tuser;
  assign busy_o       = busy;
  assign frame_done_o = frame_done;
endmodule

// File: tb/tb_axi4_video_tpg.sv
// Self-checking bench for axi4_video_tpg: cycle model plus directed beat checks on a 16x4 frame.
module tb_axi4_video_tpg;
  localparam int unsigned XR = 16, YR = 4, PW = 10, CL = 2, DW = 30;
  localparam int unsigned WXR = 2048, WYR = 2;
  localparam logic [DW-1:0] WHITE = {10'h3FF, 10'h3FF, 10'h3FF};
  localparam logic [DW-1:0] YELLOW = {10'h3FF, 10'h3FF, 10'h000};
  localparam logic [DW-1:0] CYAN = {10'h000, 10'h3FF, 10'h3FF};
  localparam logic [DW-1:0] GREEN = {10'h000, 10'h3FF, 10'h000};
  localparam logic [DW-1:0] MAGENTA = {10'h3FF, 10'h000, 10'h3FF};
  localparam logic [DW-1:0] RED = {10'h3FF, 10'h000, 10'h000};
  localparam logic [DW-1:0] BLUE = {10'h000, 10'h000, 10'h3FF};
  localparam logic [DW-1:0] BLACK = {DW{1'b0}};
  localparam logic [DW-1:0] BARS [8] = '{WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK};
  localparam logic [DW-1:0] SOLID = {10'h155, 10'h2AA, 10'h0F0};

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, w_en = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic [DW-1:0] solid = '0;
  logic busy, frame_done, w_busy, w_done;
  logic chk_en = 1'b0, rand_rdy = 1'b0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  axi4_video_tpg_if #(.PX_WIDTH(PW)) vid ();
  axi4_video_tpg_if #(.PX_WIDTH(PW)) wvid ();
  assign wvid.tready = 1'b1;

  axi4_video_tpg #(.X_RES(XR), .Y_RES(YR), .PX_WIDTH(PW), .CHECK_LOG2(CL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .pattern_i(pattern),
    .solid_color_i(solid), .video(vid.master), .busy_o(busy), .frame_done_o(frame_done));

  axi4_video_tpg #(.X_RES(WXR), .Y_RES(WYR), .PX_WIDTH(PW), .CHECK_LOG2(CL)) dut_wide (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(w_en), .pattern_i(2'd1),
    .solid_color_i({DW{1'b0}}), .video(wvid.master), .busy_o(w_busy), .frame_done_o(w_done));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_pix(input int xx, input int yy, input int off,
                                            input int p, input logic [DW-1:0] sc);
    int xe;
    logic [PW-1:0] r;
    xe = (xx + off) % XR;
    r  = xe[PW-1:0];
    case (p)
      0:       return BARS[xe / (XR / 8)];
      1:       return {r, r, r};
      2:       return ((((xe >> CL) ^ (yy >> CL)) & 1) != 0) ? BLACK : WHITE;
      default: return sc;
    endcase
  endfunction

  // reference model state, observed beats and the wide-instance probe
  logic m_valid = 1'b0, m_done = 1'b0;
  int mx = 0, my = 0, moff = 0, mpat = 0;
  logic [DW-1:0] msolid = '0;
  logic [DW+1:0] beats[$];
  int fd_cnt = 0, w_cnt = 0;
  logic [DW-1:0] w5 = '0, w1024 = '1, w2047 = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("tvalid", 64'(vid.tvalid), 64'(m_valid));
      check("busy", 64'(busy), 64'(m_valid));
      check("frame_done", 64'(frame_done), 64'(m_done));
      if (m_valid) begin
        check("tdata", 64'(vid.tdata), 64'(ref_pix(mx, my, moff, mpat, msolid)));
        check("tuser", 64'(vid.tuser), 64'(mx == 0 && my == 0));
        check("tlast", 64'(vid.tlast), 64'(mx == XR - 1));
      end
    end
    if (!rst_n) begin
      beats.delete();
      fd_cnt = 0;
      w_cnt  = 0;
      m_valid = 1'b0; m_done = 1'b0; mx = 0; my = 0; moff = 0; mpat = 0; msolid = '0;
    end else begin
      if (vid.tvalid && vid.tready) beats.push_back({vid.tdata, vid.tuser, vid.tlast});
      if (frame_done) fd_cnt++;
      if (wvid.tvalid) begin
        if (w_cnt == 5) w5 = wvid.tdata;
        if (w_cnt == 1024) w1024 = wvid.tdata;
        if (w_cnt == 2047) w2047 = wvid.tdata;
        w_cnt++;
      end
      m_done = 1'b0;
      if (!m_valid) begin
        if (enable) begin
          m_valid = 1'b1; mx = 0; my = 0; mpat = int'(pattern); msolid = solid;
        end
      end else if (vid.tready) begin
        if (mx == XR - 1 && my == YR - 1) begin
          m_done = 1'b1;
          if (enable) begin
            mx = 0; my = 0; mpat = int'(pattern); msolid = solid;
`ifdef TPG_SCROLL_EN
            moff = (moff + 1) % XR;
`endif
          end else begin
            m_valid = 1'b0;
          end
        end else if (mx == XR - 1) begin
          mx = 0; my++;
        end else begin
          mx++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) vid.tready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; pattern = 2'd0; solid = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic wait_beats(input string tag, input int n);
    int b = 0;
    while (beats.size() < n && b < 2000) begin step(); b++; end
    check({tag, "_reached"}, 64'(beats.size() >= n), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while (vid.tvalid && b < 2000) begin step(); b++; end
    check({tag, "_idle"}, 64'(vid.tvalid), 64'd0);
    step(); step();
  endtask

  logic [DW+1:0] s1[$];
  int nuser;

  initial begin
    vid.tready = 1'b1;
    repeat (3) step();
    check("rst_tvalid", 64'(vid.tvalid), 64'd0);
    check("rst_tdata", 64'(vid.tdata), 64'd0);
    check("rst_tlast", 64'(vid.tlast), 64'd0);
    check("rst_tuser", 64'(vid.tuser), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // single bars frame, always ready
    pattern = 2'd0; enable = 1'b1;
    step();
    check("s1_latency", 64'(vid.tvalid), 64'd1);
    enable = 1'b0;
    wait_idle("s1");
    check("s1_count", 64'(beats.size()), 64'd64);
    check("s1_beat0", 64'(beats[0]), 64'({WHITE, 1'b1, 1'b0}));
    check("s1_x2", 64'(beats[2]), 64'({YELLOW, 1'b0, 1'b0}));
    check("s1_x15", 64'(beats[15]), 64'({BLACK, 1'b0, 1'b1}));
    check("s1_fdone", 64'(fd_cnt), 64'd1);
    s1 = beats;

    // same frame under random back-pressure
    do_reset();
    rand_rdy = 1'b1; enable = 1'b1;
    step();
    enable = 1'b0;
    wait_idle("s2");
    rand_rdy = 1'b0; vid.tready = 1'b1;
    check("s2_count", 64'(beats.size()), 64'd64);
    for (int i = 0; i < 64 && i < beats.size(); i++) check("s2_beat", 64'(beats[i]), 64'(s1[i]));

    // enable dropped mid-frame
    do_reset();
    enable = 1'b1;
    step();
    wait_beats("s3", 10);
    enable = 1'b0;
    wait_idle("s3");
    repeat (3) step();
    check("s3_count", 64'(beats.size()), 64'd64);
    for (int i = 15; i < 64 && i < beats.size(); i += 16) check("s3_tlast", 64'(beats[i][0]), 64'd1);
    nuser = 0;
    foreach (beats[i]) nuser += int'(beats[i][1]);
    check("s3_nuser", 64'(nuser), 64'd1);
    check("s3_busy", 64'(busy), 64'd0);

    // pattern switch mid-frame takes effect at the next SOF
    do_reset();
    enable = 1'b1;
    step();
    wait_beats("s4a", 5);
    pattern = 2'd2;
    wait_beats("s4b", 65);
    enable = 1'b0;
    wait_idle("s4");
    check("s4_count", 64'(beats.size()), 64'd128);
    check("s4_f1x6", 64'(beats[6]), 64'({GREEN, 1'b0, 1'b0}));
    check("s4_f1x9", 64'(beats[9]), 64'({MAGENTA, 1'b0, 1'b0}));
    check("s4_f2b0", 64'(beats[64]), 64'({WHITE, 1'b1, 1'b0}));
    check("s4_f2x4", 64'(beats[68][DW+1:2]), 64'(BLACK));
    check("s4_fdone", 64'(fd_cnt), 64'd2);

    // grey ramp
    do_reset();
    pattern = 2'd1; enable = 1'b1;
    step();
    enable = 1'b0;
    wait_idle("s5");
    check("s5_x5", 64'(beats[5][DW+1:2]), 64'({10'h005, 10'h005, 10'h005}));

    // solid colour latched at SOF, later input changes ignored
    do_reset();
    pattern = 2'd3; solid = SOLID; enable = 1'b1;
    step();
    enable = 1'b0; solid = '0; pattern = 2'd0;
    wait_idle("s6");
    check("s6_b7", 64'(beats[7][DW+1:2]), 64'(SOLID));
    check("s6_b63", 64'(beats[63][DW+1:2]), 64'(SOLID));

    // reset mid-frame abandons the frame
    do_reset();
    enable = 1'b1;
    step();
    enable = 1'b0;
    wait_beats("s7", 20);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("s7_tvalid", 64'(vid.tvalid), 64'd0);
    check("s7_busy", 64'(busy), 64'd0);
    repeat (3) step();
    check("s7_nodone", 64'(fd_cnt), 64'd0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    wait_idle("s7r");
    check("s7_count", 64'(beats.size()), 64'd64);
    check("s7_b0", 64'(beats[0]), 64'({WHITE, 1'b1, 1'b0}));

    // back-to-back frames; scroll shifts the second frame by one pixel
    do_reset();
    enable = 1'b1;
    step();
    wait_beats("s8", 65);
    enable = 1'b0;
    wait_idle("s8");
`ifdef TPG_SCROLL_EN
    check("s8_f2x1", 64'(beats[65][DW+1:2]), 64'(YELLOW));
`else
    check("s8_f2x1", 64'(beats[65][DW+1:2]), 64'(WHITE));
`endif
    check("s8_f2b0_user", 64'(beats[64][1]), 64'd1);

    // wide instance: ramp wraps modulo 2^PX_WIDTH
    do_reset();
    w_en = 1'b1;
    step();
    w_en = 1'b0;
    for (int b = 0; b < 5000 && w_cnt < WXR * WYR; b++) step();
    repeat (3) step();
    check("w_count", 64'(w_cnt), 64'(WXR * WYR));
    check("w_x5", 64'(w5), 64'({10'h005, 10'h005, 10'h005}));
    check("w_x1024", 64'(w1024), 64'd0);
    check("w_x2047", 64'(w2047), 64'({10'h3FF, 10'h3FF, 10'h3FF}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
